// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multicycle core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects.
//
// Ports:
//   clk        core clock, rising edge
//   rst        synchronous reset, active-low
//   opcode     IR[15:12], looked at only in DECODE and MEM_ADDR
//   zero       ALU zero flag (same cycle)
//   mem_ready  memory access completes this cycle
//   pc_write, ir_write, mem_write, reg_write   datapath write strobes
//   mem_read, iord, reg_dst                    memory / register controls
//   alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg   mux selects
//   state      current state (debug)
//   instr_done last cycle of an instruction
//   illegal    one-cycle pulse on an undefined opcode
//   halted     high while in HALT
module multicycle_ctrl #(
    parameter int OPW = 4,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           ir_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           iord,
    output logic           reg_write,
    output logic           reg_dst,
    output logic [1:0]     alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [2:0]     alu_op,
    output logic [1:0]     pc_src,
    output logic [1:0]     mem_to_reg,
    output logic [STW-1:0] state,
    output logic           instr_done,
    output logic           illegal,
    output logic           halted
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_LW   = OPW'(2);
    localparam logic [OPW-1:0] OP_SW   = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
    localparam logic [OPW-1:0] OP_HALT = {OPW{1'b1}};

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_FN  = 3'b010;

    // Pure Moore part of the output set; registered alongside state.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
        logic       done;
        logic       halted;
    } ctl_t;

    state_t cur;
    state_t nxt;
    ctl_t   ctl;
    logic   op_legal;

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        c.alu_op = ALU_ADD;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: begin
                c.alu_src_b = 2'b10;
            end
            EXEC_R: begin
                c.alu_src_a = 2'b01;
                c.alu_op    = ALU_FN;
            end
            EXEC_I, MEM_ADDR: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            WB_R: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            WB_I: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.done      = 1'b1;
            end
            WB_MEM: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.mem_to_reg = 2'b01;
                c.done       = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 2'b01;
                c.alu_op    = ALU_SUB;
                c.pc_src    = 2'b01;
                c.done      = 1'b1;
            end
            JUMP: begin
                c.pc_src = 2'b10;
                c.done   = 1'b1;
            end
            HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    assign op_legal = (opcode == OP_R)    ||
                      (opcode == OP_ADDI) ||
                      (opcode == OP_LW)   ||
                      (opcode == OP_SW)   ||
                      (opcode == OP_BEQ)  ||
                      (opcode == OP_JMP)  ||
                      (opcode == OP_HALT);

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH: begin
                if (mem_ready) nxt = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    opcode == OP_R:    nxt = EXEC_R;
                    opcode == OP_ADDI: nxt = EXEC_I;
                    opcode == OP_LW:   nxt = MEM_ADDR;
                    opcode == OP_SW:   nxt = MEM_ADDR;
                    opcode == OP_BEQ:  nxt = BRANCH;
                    opcode == OP_JMP:  nxt = JUMP;
                    opcode == OP_HALT: nxt = HALT;
                    default:           nxt = FETCH;
                endcase
            end
            EXEC_R:   nxt = WB_R;
            EXEC_I:   nxt = WB_I;
            MEM_ADDR: nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (mem_ready) nxt = WB_MEM;
            end
            MEM_WR: begin
                if (mem_ready) nxt = FETCH;
            end
            WB_R, WB_I, WB_MEM: nxt = FETCH;
            BRANCH, JUMP:       nxt = FETCH;
            HALT:               nxt = HALT;
            default:            nxt = FETCH;
        endcase
    end

    // Moore outputs are precomputed from the next state so they
    // change together with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur <= FETCH;
            ctl <= decode(FETCH);
        end else begin
            cur <= nxt;
            ctl <= decode(nxt);
        end
    end

    assign state      = STW'(cur);
    assign mem_read   = ctl.mem_read;
    assign iord       = ctl.iord;
    assign reg_dst    = ctl.reg_dst;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign pc_src     = ctl.pc_src;
    assign mem_to_reg = ctl.mem_to_reg;
    assign halted     = ctl.halted;

    // Strobes are forced low while reset is held, independent of state.
    assign pc_write  = rst & (((cur == FETCH) & mem_ready) |
                              ((cur == BRANCH) & zero) |
                              (cur == JUMP));
    assign ir_write  = rst & (cur == FETCH) & mem_ready;
    assign mem_write = rst & ctl.mem_write;
    assign reg_write = rst & ctl.reg_write;

    assign illegal    = rst & (cur == DECODE) & ~op_legal;
    assign instr_done = rst & (ctl.done |
                               ((cur == MEM_WR) & mem_ready) |
                               ((cur == DECODE) & ~op_legal));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Expected outputs per cycle are queued when driven and popped at sample time.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;
    logic       halted;

    multicycle_ctrl #(.OPW(4), .STW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_BAD  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] op;
        logic [1:0] pc_src;
        logic [1:0] m2r;
        logic       done;
        logic       illegal;
        logic       halted;
    } out_t;

    typedef struct {
        logic [3:0] st;
        out_t       o;
        int         step;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    stepn  = 0;

    function automatic logic legal(input logic [3:0] op);
        return (op <= 4'd5) || (op == 4'd15);
    endfunction

    // Output table for one cycle, given the state the DUT should be in.
    function automatic out_t model(input logic [3:0] st, input logic r,
                                   input logic mr, input logic z,
                                   input logic [3:0] op);
        out_t o;
        o = '0;
        case (st)
            4'd0: begin
                o.mem_read = 1'b1;
                o.b        = 2'b01;
                o.pc_write = mr;
                o.ir_write = mr;
            end
            4'd1: begin
                o.b = 2'b10;
                if (!legal(op)) begin
                    o.illegal = 1'b1;
                    o.done    = 1'b1;
                end
            end
            4'd2: begin
                o.a  = 2'b01;
                o.op = 3'b010;
            end
            4'd3, 4'd4: begin
                o.a = 2'b01;
                o.b = 2'b10;
            end
            4'd5: begin
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
            end
            4'd6: begin
                o.mem_write = 1'b1;
                o.iord      = 1'b1;
                o.done      = mr;
            end
            4'd7: begin
                o.reg_write = 1'b1;
                o.done      = 1'b1;
            end
            4'd8: begin
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
                o.done      = 1'b1;
            end
            4'd9: begin
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
                o.m2r       = 2'b01;
                o.done      = 1'b1;
            end
            4'd10: begin
                o.a        = 2'b01;
                o.op       = 3'b001;
                o.pc_src   = 2'b01;
                o.pc_write = z;
                o.done     = 1'b1;
            end
            4'd11: begin
                o.pc_src   = 2'b10;
                o.pc_write = 1'b1;
                o.done     = 1'b1;
            end
            4'd12: begin
                o.halted = 1'b1;
            end
            default: o = '0;
        endcase
        if (!r) begin
            o.pc_write  = 1'b0;
            o.ir_write  = 1'b0;
            o.mem_write = 1'b0;
            o.reg_write = 1'b0;
            o.done      = 1'b0;
            o.illegal   = 1'b0;
        end
        return o;
    endfunction

    // One clock cycle: drive inputs, queue expectation, sample, advance.
    task automatic cyc(input logic r, input logic mr, input logic z,
                       input logic [3:0] op, input logic [3:0] st);
        item_t it;
        out_t  obs;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        it.st   = st;
        it.o    = model(st, r, mr, z, op);
        it.step = stepn;
        stepn++;
        sb.push_back(it);
        #2;
        it  = sb.pop_front();
        obs = {pc_write, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
               pc_src, mem_to_reg, instr_done, illegal, halted};
        checks++;
        assert (state === it.st) else begin
            errors++;
            $error("FAIL state step %0d: got %0d want %0d",
                   it.step, state, it.st);
        end
        checks++;
        assert (obs === it.o) else begin
            errors++;
            $error("FAIL outputs step %0d st %0d: got %h want %h",
                   it.step, it.st, obs, it.o);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = OP_R;
        repeat (2) @(posedge clk);
        #1;
        // reset held: FETCH, strobes gated off
        cyc(0, 1, 0, OP_R, 4'd0);
        // R-type, opcode disturbed outside DECODE
        cyc(1, 1, 0, OP_R, 4'd0);
        cyc(1, 1, 0, OP_R, 4'd1);
        cyc(1, 1, 0, OP_JMP, 4'd2);
        cyc(1, 1, 0, OP_HALT, 4'd7);
        // LW with three MEM_RD stall cycles
        cyc(1, 1, 0, OP_LW, 4'd0);
        cyc(1, 1, 0, OP_LW, 4'd1);
        cyc(1, 1, 0, OP_LW, 4'd4);
        cyc(1, 0, 0, OP_LW, 4'd5);
        cyc(1, 0, 0, OP_LW, 4'd5);
        cyc(1, 0, 0, OP_LW, 4'd5);
        cyc(1, 1, 0, OP_LW, 4'd5);
        cyc(1, 1, 0, OP_LW, 4'd9);
        // fetch stall, then ADDI
        cyc(1, 0, 0, OP_ADDI, 4'd0);
        cyc(1, 1, 0, OP_ADDI, 4'd0);
        cyc(1, 1, 0, OP_ADDI, 4'd1);
        cyc(1, 0, 0, OP_R, 4'd3);
        cyc(1, 1, 0, OP_R, 4'd8);
        // SW without stall
        cyc(1, 1, 0, OP_SW, 4'd0);
        cyc(1, 1, 0, OP_SW, 4'd1);
        cyc(1, 1, 0, OP_SW, 4'd4);
        cyc(1, 1, 0, OP_SW, 4'd6);
        // BEQ taken, then not taken
        cyc(1, 1, 0, OP_BEQ, 4'd0);
        cyc(1, 1, 0, OP_BEQ, 4'd1);
        cyc(1, 1, 1, OP_BEQ, 4'd10);
        cyc(1, 1, 0, OP_BEQ, 4'd0);
        cyc(1, 1, 1, OP_BEQ, 4'd1);
        cyc(1, 1, 0, OP_BEQ, 4'd10);
        // JMP
        cyc(1, 1, 0, OP_JMP, 4'd0);
        cyc(1, 1, 0, OP_JMP, 4'd1);
        cyc(1, 1, 0, OP_JMP, 4'd11);
        // illegal opcode acts as a NOP
        cyc(1, 1, 0, OP_BAD, 4'd0);
        cyc(1, 1, 0, OP_BAD, 4'd1);
        // HALT holds for 20 cycles regardless of inputs
        cyc(1, 1, 0, OP_HALT, 4'd0);
        cyc(1, 1, 0, OP_HALT, 4'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, i[0], i[1], 4'(i), 4'd12);
        end
        cyc(0, 1, 0, OP_R, 4'd12);
        // SW stalled, reset on second stall cycle
        cyc(1, 1, 0, OP_SW, 4'd0);
        cyc(1, 1, 0, OP_SW, 4'd1);
        cyc(1, 1, 0, OP_SW, 4'd4);
        cyc(1, 0, 0, OP_SW, 4'd6);
        cyc(0, 0, 0, OP_SW, 4'd6);
        cyc(1, 1, 0, OP_JMP, 4'd0);
        cyc(1, 1, 0, OP_JMP, 4'd1);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard: got %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
